noc_rr_port_scheduler: RTL and testbench

- Clocked N-input round-robin scheduler that shares one router output port between N packet requesters (local PE plus neighbour links).
- Each input uses a four-phase req/ack handshake. The granted packet is registered and presented on a valid/ready output toward the link/FIFO.
- Arbitration is packet-level: one whole 57-bit packet per grant. Fairness rotates past the last winner.

---
 rtl/noc_pkg.sv | 19 +
 rtl/rr_pick.sv | 29 ++
 rtl/noc_rr_port_scheduler.sv | 130 +++++++++++++
 tb/tb_noc_rr_port_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared router types: packet width, default port count, scheduler state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  localparam int WIDTH_PKT      = 57;
  localparam int NUM_IN_DEFAULT = 4;

  // DRAIN is reserved: encoded so every 2-bit value is legal, but never entered.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2,
    SEND  = 2'd3
  } sched_state_t;

  typedef logic [WIDTH_PKT-1:0] packet_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NUM_IN.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int PTR_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic              found,
  output logic [PTR_W-1:0]  winner
);

  logic [2*NUM_IN-1:0] mask;
  logic [2*NUM_IN-1:0] cand;

  // Duplicate the request vector, mask off bits below ptr in the lower copy and
  // take the lowest surviving bit; the upper copy supplies the wrapped search.
  always_comb begin
    mask   = {(2*NUM_IN){1'b1}} << ptr;
    cand   = {req, req} & mask;
    found  = |req;
    winner = '0;
    for (int i = 2*NUM_IN-1; i >= 0; i--) begin
      if (cand[i]) winner = PTR_W'(i % NUM_IN);
    end
  end

endmodule

// File: rtl/noc_rr_port_scheduler.sv
// Packet-level round-robin scheduler sharing one router output port among NUM_IN four-phase requesters.
// Latency: req high -> ack 1 edge; req low -> out_valid 1 edge; grant->idle after out_ready.
// Backpressure: out_ready low holds SEND with data stable and all acks low. Option: NOC_SCHED_GRANT_CNT_EN adds grant counters.
module noc_rr_port_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEFAULT,
  parameter int PTR_W  = $clog2(NUM_IN)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_IN-1:0]                in_req,
  input  logic [NUM_IN-1:0][WIDTH_PKT-1:0] in_data,
  output logic [NUM_IN-1:0]                in_ack,
  output logic                             out_valid,
  output logic [WIDTH_PKT-1:0]             out_data,
  input  logic                             out_ready,
  output logic [PTR_W-1:0]                 grant_idx,
  output logic                             busy
`ifdef NOC_SCHED_GRANT_CNT_EN
  ,
  output logic [NUM_IN-1:0][15:0]          grant_cnt
`endif
);

  sched_state_t       state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  packet_t            data_q, data_d;
  logic [NUM_IN-1:0]  ack_q, ack_d;
  logic               valid_q, valid_d;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req    (in_req),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_idx)
  );

  // Next-state: capture in IDLE, wait for req release in ACK, wait for ready in SEND.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    data_d  = data_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    case (state_q)
      ACK: begin
        // Other requesters stay pending; only the winner's release matters.
        if (!in_req[win_q]) begin
          ack_d   = '0;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ptr_d   = (win_q == PTR_W'(NUM_IN-1)) ? '0 : win_q + PTR_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        // IDLE, and the unused DRAIN code, behave as IDLE.
        state_d = IDLE;
        if (pick_found) begin
          data_d  = in_data[pick_idx];
          win_d   = pick_idx;
          ack_d   = NUM_IN'(1) << pick_idx;
          state_d = ACK;
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any captured packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  assign in_ack    = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign grant_idx = win_q;
  assign busy      = (state_q == ACK) || (state_q == SEND);

`ifdef NOC_SCHED_GRANT_CNT_EN
  logic [NUM_IN-1:0][15:0] cnt_q, cnt_d;
  logic                    send_done;

  // Count completed transfers per winner, saturating at all-ones.
  always_comb begin
    cnt_d     = cnt_q;
    send_done = (state_q == SEND) && valid_q && out_ready;
    if (send_done && (cnt_q[win_q] != 16'hFFFF)) begin
      cnt_d[win_q] = cnt_q[win_q] + 16'd1;
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_noc_rr_port_scheduler.sv
// Directed bench for noc_rr_port_scheduler (NUM_IN=4): vector table plus hand-written corner sequences.
// Latency: one vector per clock; outputs sampled on the falling edge.
// Backpressure: exercised by a 20-cycle out_ready stall.
module tb_noc_rr_port_scheduler;

  logic              clk;
  logic              rst_n;
  logic [3:0]        in_req;
  logic [3:0][56:0]  in_data;
  logic [3:0]        in_ack;
  logic              out_valid;
  logic [56:0]       out_data;
  logic              out_ready;
  logic [1:0]        grant_idx;
  logic              busy;
`ifdef NOC_SCHED_GRANT_CNT_EN
  logic [3:0][15:0]  grant_cnt;
`endif

  noc_rr_port_scheduler #(.NUM_IN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .in_data   (in_data),
    .in_ack    (in_ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef NOC_SCHED_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] ack;
    logic       vld;
    logic [1:0] gidx;
    logic       bsy;
  } vec_t;

  localparam int NV = 14;
  vec_t        tv [NV];
  logic [56:0] dat [4];
  int          total;
  int          bad;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One complete grant: request pattern pend, expected winner w, winner drops req after ack.
  task automatic grant(input logic [3:0] pend, input int w, input string tag);
    logic [3:0] one;
    one       = 4'b0001 << w;
    in_req    = pend;
    out_ready = 1'b1;
    step();
    chk({tag, "_ack"},  {60'd0, in_ack}, {60'd0, one});
    chk({tag, "_gidx"}, {62'd0, grant_idx}, 64'(w));
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    in_req = pend & ~one;
    step();
    chk({tag, "_vld"},  {63'd0, out_valid}, 64'd1);
    chk({tag, "_ack0"}, {60'd0, in_ack}, 64'd0);
    chk({tag, "_data"}, {7'd0, out_data}, {7'd0, dat[w]});
    step();
    chk({tag, "_done_vld"},  {63'd0, out_valid}, 64'd0);
    chk({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int order [5];
    total     = 0;
    bad       = 0;
    dat[0]    = 57'h0_0000_0AAA_0000;
    dat[1]    = 57'h1_0001_2345;
    dat[2]    = 57'h1ABC;
    dat[3]    = 57'h1FF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) in_data[i] = dat[i];
    in_req    = 4'b0000;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // req, rdy, ack, vld, gidx, busy  (ptr starts at 0)
    tv[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tv[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1}; // single request to 2
    tv[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1}; // ack held while req high
    tv[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1}; // req dropped -> valid
    tv[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0}; // accepted, ptr=3
    tv[5]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1}; // wrap search 3->0
    tv[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tv[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}; // ptr=1
    tv[8]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1}; // 3 beats 0 from ptr=1
    tv[9]  = '{4'b0001, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1}; // 0 stays pending
    tv[10] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0}; // ptr wraps to 0
    tv[11] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1}; // pending 0 now wins
    tv[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tv[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}; // ptr=1

    #3;
    chk("rst_ack",  {60'd0, in_ack}, 64'd0);
    chk("rst_vld",  {63'd0, out_valid}, 64'd0);
    chk("rst_data", {7'd0, out_data}, 64'd0);
    chk("rst_gidx", {62'd0, grant_idx}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      logic [56:0] exp_data;
      in_req    = tv[i].req;
      out_ready = tv[i].rdy;
      step();
      exp_data = (i == 0) ? 57'd0 : dat[tv[i].gidx];
      chk($sformatf("v%0d_ack", i),  {60'd0, in_ack}, {60'd0, tv[i].ack});
      chk($sformatf("v%0d_vld", i),  {63'd0, out_valid}, {63'd0, tv[i].vld});
      chk($sformatf("v%0d_gidx", i), {62'd0, grant_idx}, {62'd0, tv[i].gidx});
      chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, tv[i].bsy});
      chk($sformatf("v%0d_data", i), {7'd0, out_data}, {7'd0, exp_data});
    end

    // All four requesting continuously from ptr=1: strict rotation.
    order = '{1, 2, 3, 0, 1};
    for (int g = 0; g < 5; g++) grant(4'b1111, order[g], $sformatf("rr%0d", g));

    // Backpressure: grant to 2 (ptr=2), then hold out_ready low for 20 cycles.
    in_req    = 4'b1111;
    out_ready = 1'b0;
    step();
    chk("stall_ack", {60'd0, in_ack}, 64'h4);
    in_req = 4'b1011;
    step();
    chk("stall_enter_vld", {63'd0, out_valid}, 64'd1);
    in_data[2] = 57'h0DEAD; // legal now that req[2] is low; must not reach out_data
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("stall%0d_vld", c),  {63'd0, out_valid}, 64'd1);
      chk($sformatf("stall%0d_data", c), {7'd0, out_data}, {7'd0, dat[2]});
      chk($sformatf("stall%0d_ack", c),  {60'd0, in_ack}, 64'd0);
    end
    in_data[2] = dat[2];
    out_ready  = 1'b1;
    step();
    chk("stall_rel_vld",  {63'd0, out_valid}, 64'd0);
    chk("stall_rel_busy", {63'd0, busy}, 64'd0);
    grant(4'b1011, 3, "post_stall");

    // Asynchronous reset while input 1 is in ACK (ptr=0).
    in_req = 4'b0010;
    step();
    chk("pre_rst_ack", {60'd0, in_ack}, 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",  {60'd0, in_ack}, 64'd0);
    chk("mid_rst_vld",  {63'd0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_data", {7'd0, out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    grant(4'b0010, 1, "after_rst");

`ifdef NOC_SCHED_GRANT_CNT_EN
    for (int k = 0; k < 10; k++) grant(4'b0001, 0, $sformatf("cnt0_%0d", k));
    for (int k = 0; k < 3; k++)  grant(4'b0100, 2, $sformatf("cnt2_%0d", k));
    chk("cnt0", {48'd0, grant_cnt[0]}, 64'd10);
    chk("cnt1", {48'd0, grant_cnt[1]}, 64'd1);
    chk("cnt2", {48'd0, grant_cnt[2]}, 64'd3);
    chk("cnt3", {48'd0, grant_cnt[3]}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
